// File: rtl/vga_scan_compositor.sv
// rtl/vga_scan_compositor.sv - VGA raster generator with sticker-layer compositing
// Layer answers arrive LAYER_LAT enabled clocks after o_x/o_y; black (0/0/0) is transparent.
module vga_scan_compositor #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int LAYER_LAT = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [10:0] i_pos_x,
  input  logic [10:0] i_pos_y,
  input  logic [23:0] i_bg_rgb,
  input  logic [23:0] i_layer_rgb,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic [10:0] o_sticker_x,
  output logic [10:0] o_sticker_y,
  output logic [7:0]  o_vga_r,
  output logic [7:0]  o_vga_g,
  output logic [7:0]  o_vga_b,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_blank_n,
  output logic        o_frame_start
);

  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
  localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [10:0] h_cnt, v_cnt;
  logic        h_wrap, v_wrap;
  logic        active_0, hs_0, vs_0;
  logic [2:0]  dly_out;
  logic [23:0] pix;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (i_en) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  assign active_0 = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_0     = !((h_cnt >= H_SS) && (h_cnt < H_SE));
  assign vs_0     = !((v_cnt >= V_SS) && (v_cnt < V_SE));
  assign o_x      = active_0 ? h_cnt : 11'd0;
  assign o_y      = active_0 ? v_cnt : 11'd0;

  // Timing bits ride alongside the layer's own latency so they meet its answer.
  generate
    if (LAYER_LAT == 0) begin : g_no_dly
      assign dly_out = {active_0, hs_0, vs_0};
    end else begin : g_dly
      logic [LAYER_LAT-1:0][2:0] dly_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          dly_q <= {LAYER_LAT{3'b011}};
        end else if (i_en) begin
          dly_q[0] <= {active_0, hs_0, vs_0};
          for (int i = 1; i < LAYER_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign dly_out = dly_q[LAYER_LAT-1];
    end
  endgenerate

  assign pix = (i_layer_rgb == 24'd0) ? i_bg_rgb : i_layer_rgb;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vga_r   <= '0;
      o_vga_g   <= '0;
      o_vga_b   <= '0;
      o_hs      <= 1'b1;
      o_vs      <= 1'b1;
      o_blank_n <= 1'b0;
    end else if (i_en) begin
      o_blank_n <= dly_out[2];
      o_hs      <= dly_out[1];
      o_vs      <= dly_out[0];
      o_vga_r   <= dly_out[2] ? pix[7:0]   : 8'd0;
      o_vga_g   <= dly_out[2] ? pix[15:8]  : 8'd0;
      o_vga_b   <= dly_out[2] ? pix[23:16] : 8'd0;
    end
  end

  // Positions are only sampled at vertical-blank start so a frame never tears.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sticker_x   <= '0;
      o_sticker_y   <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= i_en && h_wrap && v_wrap;
      if (i_en && (h_cnt == 11'd0) && (v_cnt == V_VIS)) begin
        o_sticker_x <= i_pos_x;
        o_sticker_y <= i_pos_y;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_compositor.sv
// tb/tb_vga_scan_compositor.sv - scoreboard bench for vga_scan_compositor
// Small raster geometry; reference model derives every output from an enabled-clock count.
module tb_vga_scan_compositor;

  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [10:0] pos_x = '0, pos_y = '0;
  logic [23:0] bg_rgb = '0, layer_rgb = '0;
  logic [10:0] o_x, o_y, o_sticker_x, o_sticker_y;
  logic [7:0]  o_vga_r, o_vga_g, o_vga_b;
  logic        o_hs, o_vs, o_blank_n, o_frame_start;

  vga_scan_compositor #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .LAYER_LAT(LAT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_pos_x(pos_x), .i_pos_y(pos_y),
    .i_bg_rgb(bg_rgb), .i_layer_rgb(layer_rgb),
    .o_x(o_x), .o_y(o_y),
    .o_sticker_x(o_sticker_x), .o_sticker_y(o_sticker_y),
    .o_vga_r(o_vga_r), .o_vga_g(o_vga_g), .o_vga_b(o_vga_b),
    .o_hs(o_hs), .o_vs(o_vs), .o_blank_n(o_blank_n),
    .o_frame_start(o_frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] x, y, sx, sy;
    logic [23:0] rgb;
    logic        hs, vs, bl, fs;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   total = 0;
  int   bad = 0;
  int   n = 0;
  int   cyc = 0;
  logic [23:0] hist [LAT];
  logic [23:0] prev_cur, cur;
  logic        shift_pending = 1'b0;

  function automatic logic [23:0] layer_f(int x, int y);
    int k;
    k = (x * 5 + y * 11) % 7;
    if (k < 3) return 24'd0;
    if (k == 3) return 24'h010101;
    return {8'(x + 17), 8'(y * 9 + 1), 8'(x * 3 + y + 1)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs after the upcoming rising edge, from the inputs driven for it.
  task automatic model_step();
    exp_t e;
    int c, p, h, v, q;
    e = last;
    if (!rst_n) begin
      e.x = '0; e.y = '0; e.sx = '0; e.sy = '0; e.rgb = '0;
      e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; e.fs = 1'b0;
      n = 0;
    end else if (!en) begin
      e.fs = 1'b0;
    end else begin
      c = n;
      if (c >= LAT) begin
        p = (c - LAT) % FRAME;
        h = p % HT;
        v = p / HT;
        e.bl = (h < HA) && (v < VA);
        e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
        if (e.bl) e.rgb = (layer_f(h, v) != 24'd0) ? layer_f(h, v) : bg_rgb;
        else      e.rgb = '0;
      end else begin
        e.bl = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.rgb = '0;
      end
      p = c % FRAME;
      if ((p % HT == 0) && (p / HT == VA)) begin
        e.sx = pos_x;
        e.sy = pos_y;
      end
      n = c + 1;
      q = n % FRAME;
      h = q % HT;
      v = q / HT;
      e.x  = ((h < HA) && (v < VA)) ? 11'(h) : 11'd0;
      e.y  = ((h < HA) && (v < VA)) ? 11'(v) : 11'd0;
      e.fs = (q == 0);
    end
    last = e;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rgb", {40'd0, o_vga_b, o_vga_g, o_vga_r}, {40'd0, e.rgb});
        check("hs_vs_blank", {61'd0, o_hs, o_vs, o_blank_n}, {61'd0, e.hs, e.vs, e.bl});
        check("xy", {42'd0, o_y, o_x}, {42'd0, e.y, e.x});
        check("sticker", {42'd0, o_sticker_y, o_sticker_x}, {42'd0, e.sy, e.sx});
        check("frame_start", {63'd0, o_frame_start}, {63'd0, e.fs});
      end
    end
  end

  initial begin : stim
    int burst;
    int rst_at;
    int rst_hold;
    burst = 0;
    rst_hold = 0;
    rst_at = 2600 + $urandom_range(0, 400);
    for (int j = 0; j < LAT; j++) hist[j] = '0;
    prev_cur = '0;
    pos_x = 11'd320;
    pos_y = 11'd240;
    bg_rgb = {8'd30, 8'd20, 8'd10};
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      cyc = i;
      if (shift_pending) begin
        for (int j = LAT - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = prev_cur;
      end
      if (i == rst_at) begin
        rst_n = 1'b0;
        rst_hold = 3;
        #1;
        check("async_rst_sync", {61'd0, o_hs, o_vs, o_blank_n}, {61'd0, 3'b110});
        check("async_rst_rgb", {40'd0, o_vga_b, o_vga_g, o_vga_r}, 64'd0);
        check("async_rst_xy", {42'd0, o_y, o_x}, 64'd0);
        check("async_rst_sticker", {42'd0, o_sticker_y, o_sticker_x}, 64'd0);
      end else if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if (i == 4) begin
        rst_n = 1'b1;
      end
      if (burst > 0) begin
        burst--;
        en = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        burst = $urandom_range(10, 40);
        en = 1'b0;
      end else begin
        en = (i >= 4) && ($urandom_range(0, 7) != 0);
      end
      if ($urandom_range(0, 49) == 0) begin
        pos_x = 11'($urandom_range(0, 2047));
        pos_y = 11'($urandom_range(0, 2047));
      end
      if ($urandom_range(0, 99) == 0) bg_rgb = 24'($urandom);
      cur = layer_f(int'(o_x), int'(o_y));
      layer_rgb = hist[LAT-1];
      model_step();
      shift_pending = en && rst_n;
      prev_cur = cur;
    end
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
